// File: rtl/cd_clk_seq_if.sv
// cd_clk_seq_if: lock input, divider controls and sequencer outputs for cd_clk_seq.
// The slave modport is the sequencer side; master is the driving/observing side.
interface cd_clk_seq_if #(
  parameter int unsigned CHN   = 2,
  parameter int unsigned ACC_W = 16
);
  logic                   pll_lock;
  logic [CHN-1:0]         div_en;
  logic [CHN*ACC_W-1:0]   div_inc;
  logic                   sys_rst;
  logic                   lock_ok;
  logic [CHN-1:0]         clk_en;
  logic [7:0]             relock_cnt;

  modport master (
    output pll_lock, div_en, div_inc,
    input  sys_rst, lock_ok, clk_en, relock_cnt
  );

  modport slave (
    input  pll_lock, div_en, div_inc,
    output sys_rst, lock_ok, clk_en, relock_cnt
  );
endinterface

// File: rtl/cd_clk_seq.sv
// cd_clk_seq: PLL lock qualifier and reset sequencer with per-channel
// phase-accumulator clock-enable generators.
// Optional feature: define CD_RELOCK_CNT_EN to count RUN->LOST transitions
// (saturating at 255); otherwise relock_cnt is tied to 0.
module cd_clk_seq #(
  parameter int unsigned CHN         = 2,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic           clk,
  input  logic           reset,
  cd_clk_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE - 1);

  state_t            state_q, state_d;
  logic [15:0]       stab_q, stab_d;
  logic              sync1_q;
  logic              lock_s_q;
  logic [ACC_W-1:0]  acc_q [CHN];
  logic [ACC_W:0]    sum   [CHN];
  logic [CHN-1:0]    clk_en_q;
  logic              run_stay;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  // Next-state and stability counter logic.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        if (lock_s_q) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 16'd1;
        end
      end
      RUN: begin
        stab_d = '0;
        if (!lock_s_q) state_d = LOST;
      end
      LOST: begin
        stab_d  = '0;
        state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = '0;
      end
    endcase
  end

  // Accumulate only while RUN is held into the next cycle, so the edge that
  // enters LOST already clears accumulators and clk_en.
  assign run_stay = (state_q == RUN) && lock_s_q;

  // Per-channel accumulator sum with carry-out.
  always_comb begin
    for (int unsigned n = 0; n < CHN; n++) begin
      sum[n] = {1'b0, acc_q[n]} + {1'b0, bus.div_inc[n*ACC_W +: ACC_W]};
    end
  end

  // Phase accumulators and clock-enable pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < CHN; n++) acc_q[n] <= '0;
      clk_en_q <= '0;
    end else begin
      for (int unsigned n = 0; n < CHN; n++) begin
        if (run_stay && bus.div_en[n]) begin
          acc_q[n]    <= sum[n][ACC_W-1:0];
          clk_en_q[n] <= sum[n][ACC_W];
        end else begin
          acc_q[n]    <= '0;
          clk_en_q[n] <= 1'b0;
        end
      end
    end
  end

`ifdef CD_RELOCK_CNT_EN
  logic [7:0] relock_q;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      relock_q <= '0;
    end else if ((state_q == RUN) && (state_d == LOST) && (relock_q != 8'hFF)) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign bus.relock_cnt = relock_q;
`else
  assign bus.relock_cnt = '0;
`endif

  assign bus.sys_rst = (state_q != RUN);
  assign bus.lock_ok = (state_q == RUN);
  assign bus.clk_en  = clk_en_q;

endmodule

// File: tb/tb_cd_clk_seq.sv
// Testbench for cd_clk_seq: lock sequencing, divider rates, loss/relock,
// reset priority and relock counter saturation.
module tb_cd_clk_seq;

  localparam int unsigned CHN   = 2;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned LS    = 8;
  localparam int          LAT   = 3 + LS;

  logic clk = 1'b0;
  logic reset;

  cd_clk_seq_if #(.CHN(CHN), .ACC_W(ACC_W)) bus ();

  cd_clk_seq #(.CHN(CHN), .ACC_W(ACC_W), .LOCK_STABLE(LS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int exp_relock = 0;
  logic [CHN-1:0] exp_q [$];
  longint unsigned S [CHN];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bump_relock;
`ifdef CD_RELOCK_CNT_EN
    if (exp_relock < 255) exp_relock++;
`endif
  endtask

  task automatic reset_model;
    for (int ch = 0; ch < CHN; ch++) S[ch] = 0;
  endtask

  // Ticks until sys_rst drops; n = edges since call (bounded).
  task automatic wait_release(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.sys_rst !== 1'b0 && n < 200);
  endtask

  // Scoreboard: expected clk_en pushed as each cycle's inputs are applied,
  // popped and compared after the edge.
  task automatic run_model(input int cycles, output int pulses1);
    logic [CHN-1:0] e, got;
    longint unsigned prev, inc;
    pulses1 = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int ch = 0; ch < CHN; ch++) begin
        if (bus.div_en[ch]) begin
          prev  = S[ch];
          inc   = longint'(bus.div_inc[ch*ACC_W +: ACC_W]);
          S[ch] = S[ch] + inc;
          e[ch] = ((S[ch] >> ACC_W) != (prev >> ACC_W));
        end else begin
          S[ch] = 0;
          e[ch] = 1'b0;
        end
      end
      exp_q.push_back(e);
      tick();
      got = exp_q.pop_front();
      vectors++;
      if (bus.clk_en !== got) begin
        miscompares++;
        $display("FAIL clk_en cycle %0d: got=%b exp=%b", c, bus.clk_en, got);
      end
      if (bus.clk_en[1] === 1'b1) pulses1++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.pll_lock = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.sys_rst, bus.lock_ok, bus.clk_en, bus.relock_cnt} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got sys_rst=%b lock_ok=%b clk_en=%b relock=%0d exp 1 0 00 0",
               bus.sys_rst, bus.lock_ok, bus.clk_en, bus.relock_cnt);
    end
    bus.pll_lock = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (bus.sys_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_no_lock: sys_rst got=%b exp=1", bus.sys_rst);
    end
  endtask

  task automatic test_lock_latency;
    int n;
    bus.pll_lock = 1'b1;
    wait_release(n);
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL lock_latency: got=%0d exp=%0d", n, LAT);
    end
    vectors++;
    if (bus.lock_ok !== 1'b1 || bus.clk_en !== 2'b00) begin
      miscompares++;
      $display("FAIL run_entry: lock_ok got=%b exp=1 clk_en got=%b exp=00", bus.lock_ok, bus.clk_en);
    end
    reset_model();
  endtask

  task automatic test_rates;
    int p1;
    bus.div_en  = 2'b11;
    bus.div_inc = {16'd21845, 16'd16384};
    run_model(300, p1);
    vectors++;
    if (p1 < 99 || p1 > 101) begin
      miscompares++;
      $display("FAIL third_rate: got=%0d pulses exp=100+/-1", p1);
    end
  endtask

  task automatic test_inc_change;
    int p1;
    bus.div_inc = {16'd0, 16'd32768};
    run_model(40, p1);
    vectors++;
    if (p1 != 0) begin
      miscompares++;
      $display("FAIL zero_inc: got=%0d pulses exp=0", p1);
    end
  endtask

  task automatic test_lost;
    int p1, n;
    bus.div_inc = {16'd21845, 16'd32768};
    bus.pll_lock = 1'b0;
    run_model(2, p1);
    tick();
    bump_relock();
    vectors++;
    if ({bus.sys_rst, bus.lock_ok, bus.clk_en} !== {1'b1, 1'b0, 2'b00} || bus.relock_cnt !== 8'(exp_relock)) begin
      miscompares++;
      $display("FAIL lost_state: got sys_rst=%b lock_ok=%b clk_en=%b relock=%0d exp 1 0 00 %0d",
               bus.sys_rst, bus.lock_ok, bus.clk_en, bus.relock_cnt, exp_relock);
    end
    tick();
    vectors++;
    if (bus.sys_rst !== 1'b1 || bus.clk_en !== 2'b00) begin
      miscompares++;
      $display("FAIL after_lost: got sys_rst=%b clk_en=%b exp 1 00", bus.sys_rst, bus.clk_en);
    end
    bus.div_inc = {16'd21845, 16'd16384};
    bus.pll_lock = 1'b1;
    wait_release(n);
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL relock_latency: got=%0d exp=%0d", n, LAT);
    end
    reset_model();
    run_model(12, p1);
  endtask

  task automatic test_reset_in_run;
    int n, p1;
    reset = 1'b1;
    tick();
    exp_relock = 0;
    vectors++;
    if ({bus.sys_rst, bus.lock_ok, bus.clk_en, bus.relock_cnt} !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_in_run: got sys_rst=%b lock_ok=%b clk_en=%b relock=%0d exp 1 0 00 0",
               bus.sys_rst, bus.lock_ok, bus.clk_en, bus.relock_cnt);
    end
    reset = 1'b0;
    wait_release(n);
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL reset_rerun_latency: got=%0d exp=%0d", n, LAT);
    end
    reset_model();
    run_model(8, p1);
  endtask

  task automatic test_glitch;
    int n;
    bus.pll_lock = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bump_relock();
    bus.pll_lock = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (bus.sys_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL stable_wait: sys_rst got=%b exp=1", bus.sys_rst);
    end
    bus.pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.pll_lock = 1'b1;
    wait_release(n);
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL glitch_restart: got=%0d exp=%0d", n, LAT);
    end
    vectors++;
    if (bus.relock_cnt !== 8'(exp_relock)) begin
      miscompares++;
      $display("FAIL glitch_relock: got=%0d exp=%0d", bus.relock_cnt, exp_relock);
    end
    reset_model();
  endtask

  task automatic test_relock_sat;
    int n;
    bus.div_en = 2'b00;
    for (int i = 0; i < 300; i++) begin
      bus.pll_lock = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      bump_relock();
      vectors++;
      if (bus.relock_cnt !== 8'(exp_relock)) begin
        miscompares++;
        $display("FAIL relock_cnt loss %0d: got=%0d exp=%0d", i, bus.relock_cnt, exp_relock);
      end
      bus.pll_lock = 1'b1;
      wait_release(n);
      if (n != LAT) begin
        vectors++;
        miscompares++;
        $display("FAIL sat_loop_latency %0d: got=%0d exp=%0d", i, n, LAT);
      end
    end
    vectors++;
`ifdef CD_RELOCK_CNT_EN
    if (bus.relock_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL relock_saturate: got=%0d exp=255", bus.relock_cnt);
    end
`else
    if (bus.relock_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL relock_tied: got=%0d exp=0", bus.relock_cnt);
    end
`endif
  endtask

  initial begin
    reset        = 1'b1;
    bus.pll_lock = 1'b0;
    bus.div_en   = '0;
    bus.div_inc  = '0;
    test_reset();
    test_lock_latency();
    test_rates();
    test_inc_change();
    test_lost();
    test_reset_in_run();
    test_glitch();
    test_relock_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cd_clk_seq.md
CD_CLK_SEQ -- requirements
Module: cd_clk_seq

Interface
REQ-001 Parameter CHN, 2, number of clock-enable channels (1..4).
REQ-002 Parameter ACC_W, 16, phase-accumulator width per channel (8..24).
REQ-003 Parameter LOCK_STABLE, 1024, cycles pll_lock must stay high before release (2..65535).
REQ-004 Port clk  in  1  single system clock, driven from the PLL global output.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port pll_lock  in  1  raw PLL LOCK; asynchronous to clk.
REQ-007 Port div_en  in  CHN  per-channel enable.
REQ-008 Port div_inc  in  CHN*ACC_W  per-channel phase increment; channel n occupies bits [n*ACC_W +: ACC_W].
REQ-009 Port sys_rst  out  1  active-high reset to downstream logic.
REQ-010 Port lock_ok  out  1  high only in state RUN.
REQ-011 Port clk_en  out  CHN  single-cycle enable pulses, one bit per channel.
REQ-012 Port relock_cnt  out  8  count of lock losses (see Configuration).

Function
REQ-013 pll_lock SHALL pass through a 2-flop synchroniser; lock_s is the second flop's output.
REQ-014 States: WAIT_LOCK, STABLE, RUN, LOST; a 16-bit stability counter stab_cnt.
REQ-015 WAIT_LOCK: stab_cnt held at 0; lock_s=1 -> STABLE.
REQ-016 STABLE: stab_cnt increments each cycle; lock_s=0 -> WAIT_LOCK with stab_cnt cleared; stab_cnt==LOCK_STABLE-1 with lock_s=1 -> RUN.
REQ-017 RUN: lock_s=0 -> LOST; otherwise stay.
REQ-018 LOST: lasts exactly one cycle, then WAIT_LOCK unconditionally.
REQ-019 sys_rst = 1 in every state except RUN; lock_ok = 1 only in RUN; both decoded from the state register (no extra cycle).
REQ-020 Total latency from a pll_lock rising edge to sys_rst falling edge: 3+LOCK_STABLE cycles, with pll_lock continuously high.
REQ-021 Per channel n: if state==RUN and div_en[n]=1, acc_n <= (acc_n + inc_n) mod 2^ACC_W, and clk_en[n] <= carry-out of that addition; otherwise acc_n <= 0 and clk_en[n] <= 0.
REQ-022 Average clk_en[n] rate = f_clk * inc_n / 2^ACC_W; inc_n=0 never pulses; inc_n=2^(ACC_W-1) pulses every 2nd cycle.
REQ-023 A change to div_inc SHALL take effect on the next accumulation without clearing acc_n.
REQ-024 On leaving RUN, all clk_en bits SHALL be 0 from the first cycle in LOST onward and all accumulators SHALL be cleared.
REQ-025 A pll_lock glitch shorter than 1 cycle that is missed by the synchroniser SHALL have no effect; any glitch captured by the synchroniser in STABLE SHALL restart the full LOCK_STABLE wait.

Reset
REQ-026 reset=1 at a clk edge: state WAIT_LOCK, stab_cnt 0, synchroniser flops 0, all accumulators 0, clk_en 0, sys_rst 1, lock_ok 0, relock_cnt 0.
REQ-027 reset asserted mid-RUN SHALL abort to WAIT_LOCK on the same edge; it has priority over every other transition.

Configuration
REQ-028 Macro CD_RELOCK_CNT_EN defined: relock_cnt increments by 1 on each RUN->LOST transition and saturates at 255.
REQ-029 Macro CD_RELOCK_CNT_EN undefined: no counter logic; relock_cnt is tied to 0.

Verification
REQ-030 LOCK_STABLE=8, pll_lock rises at cycle 0 and stays high -> sys_rst falls and lock_ok rises at cycle 11.
REQ-031 ACC_W=16, div_inc ch0=16384, div_en=1, in RUN -> clk_en[0] pulses every 4th cycle; ch1=21845 -> 1/3-rate pulses (pattern 3,3,3..., long-run 1 per 3.0 cycles +/-1).
REQ-032 In STABLE with stab_cnt=5, pll_lock low for 3 cycles -> state WAIT_LOCK, stab_cnt=0; full 8-cycle wait repeats after lock returns.
REQ-033 In RUN, pll_lock falls -> LOST 3 cycles later, sys_rst=1, clk_en=0, relock_cnt 0->1 (macro defined) or stays 0 (undefined); 300 losses -> relock_cnt=255.
REQ-034 reset pulsed for 1 cycle during RUN with pll_lock high -> WAIT_LOCK next cycle; RUN re-entered 3+LOCK_STABLE cycles after reset falls, with the synchroniser refilled.
